// File: rtl/pwm_dt_pkg.sv
// Shared types for the dead-time PWM output stage: FSM state encoding and
// default dead-time counter width.
package pwm_dt_pkg;

  localparam int DT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DT_TO_HIGH,
    ST_HIGH_ON,
    ST_DT_TO_LOW,
    ST_LOW_ON,
    ST_FAULT
  } pwm_dt_state_e;

endpackage

// File: rtl/pwm_dt_timer.sv
// Dead-time down-counter: loads a value, counts down by one per dec_i cycle
// and saturates at zero. zero_o flags that the count has reached zero.
module pwm_dt_timer
  import pwm_dt_pkg::*;
#(
  parameter int DtWidth = DT_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DtWidth-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DtWidth-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_dead_time.sv
// Complementary PWM driver with dead-time insertion and fault kill.
// Build option: define PWM_DT_FAULT_LATCH_EN to make FAULT sticky until
// fault_clr_i is pulsed with fault_i low; otherwise FAULT self-clears as
// soon as fault_i drops.
module pwm_dead_time
  import pwm_dt_pkg::*;
#(
  parameter int DtWidth = DT_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               pwm_i,
  input  logic [DtWidth-1:0] dead_time_i,
  input  logic               fault_i,
  input  logic               fault_clr_i,
  output logic               pwm_h_o,
  output logic               pwm_l_o,
  output logic               dt_active_o,
  output logic               fault_o
);

  localparam logic [DtWidth-1:0] DtOne = DtWidth'(1);

  pwm_dt_state_e state_q, state_d;
  logic pwm_h_q, pwm_h_d, pwm_l_q, pwm_l_d;
  logic dt_act_q, dt_act_d, fault_q, fault_d;
  logic tmr_load, tmr_dec, tmr_zero, dt_zero, fault_exit;

  // The timer holds D-1 on entry so that zero on the D-th dead-time cycle
  // means "leave now"; D=0 never loads because the DT state is skipped.
  pwm_dt_timer #(.DtWidth(DtWidth)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (dead_time_i - DtOne),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign dt_zero = (dead_time_i == '0);

`ifdef PWM_DT_FAULT_LATCH_EN
  assign fault_exit = !fault_i && fault_clr_i;
`else
  assign fault_exit = !fault_i;
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr_i;
`endif

  // Next-state logic: fault beats disable beats normal PWM tracking.
  always_comb begin
    state_d = state_q;
    tmr_dec = 1'b0;
    if (state_q == ST_FAULT) begin
      if (fault_exit) state_d = ST_IDLE;
    end else if (fault_i) begin
      state_d = ST_FAULT;
    end else if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:
          state_d = pwm_i ? (dt_zero ? ST_HIGH_ON : ST_DT_TO_HIGH)
                          : (dt_zero ? ST_LOW_ON  : ST_DT_TO_LOW);
        ST_HIGH_ON:
          if (!pwm_i) state_d = dt_zero ? ST_LOW_ON : ST_DT_TO_LOW;
        ST_LOW_ON:
          if (pwm_i)  state_d = dt_zero ? ST_HIGH_ON : ST_DT_TO_HIGH;
        // pwm_i reverting mid-interval returns to the side already safe.
        ST_DT_TO_HIGH:
          if (!pwm_i)        state_d = ST_LOW_ON;
          else if (tmr_zero) state_d = ST_HIGH_ON;
          else               tmr_dec = 1'b1;
        ST_DT_TO_LOW:
          if (pwm_i)         state_d = ST_HIGH_ON;
          else if (tmr_zero) state_d = ST_LOW_ON;
          else               tmr_dec = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
    tmr_load = (state_d == ST_DT_TO_HIGH && state_q != ST_DT_TO_HIGH) ||
               (state_d == ST_DT_TO_LOW  && state_q != ST_DT_TO_LOW);
  end

  // Output decode from the next state so outputs are registered, glitch-free.
  always_comb begin
    pwm_h_d  = (state_d == ST_HIGH_ON);
    pwm_l_d  = (state_d == ST_LOW_ON);
    dt_act_d = (state_d == ST_DT_TO_HIGH) || (state_d == ST_DT_TO_LOW);
    fault_d  = (state_d == ST_FAULT);
  end

  // State and output registers, all cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pwm_h_q  <= 1'b0;
      pwm_l_q  <= 1'b0;
      dt_act_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_h_q  <= pwm_h_d;
      pwm_l_q  <= pwm_l_d;
      dt_act_q <= dt_act_d;
      fault_q  <= fault_d;
    end
  end

  assign pwm_h_o     = pwm_h_q;
  assign pwm_l_o     = pwm_l_q;
  assign dt_active_o = dt_act_q;
  assign fault_o     = fault_q;

endmodule
